// File: rtl/hazard_pkg.sv
// Shared types and constants for the 3-stage pipeline hazard sequencer.
package hazard_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } hz_state_e;

    // Next-PC source select encodings
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_MTVEC  = 2'd2;
    localparam logic [1:0] PC_MEPC   = 2'd3;

    // mcause value the CSR file records when mem_fault accompanies trap_take
    localparam logic [31:0] MCAUSE_LOAD_FAULT = 32'd5;

    // Width of the memory-wait counter; never narrower than one bit
    function automatic int unsigned wait_cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Forwarding comparators: route the MW result to an EX operand when the MW
// instruction writes a non-zero rd that matches the operand's source register.
module fwd_unit (
    input  logic [4:0] rs1_addr_i,
    input  logic [4:0] rs2_addr_i,
    input  logic [4:0] rd_addr_i,
    input  logic       reg_wr_i,
    output logic       fwd_a_o,
    output logic       fwd_b_o
);

    logic rd_live;

    // x0 is never a forwarding source
    always_comb begin
        rd_live = reg_wr_i && (rd_addr_i != 5'd0);
        fwd_a_o = rd_live && (rd_addr_i == rs1_addr_i);
        fwd_b_o = rd_live && (rd_addr_i == rs2_addr_i);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the IF -> DE/EX -> MW pipeline: stalls on data-memory
// wait, flushes wrong-path work, selects the next PC, arbitrates interrupts,
// mret and taken branches, and turns a hung memory access into a trap.
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall/flush/trap counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W       = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_addr_EX,
    input  logic [4:0]       rs2_addr_EX,
    input  logic [4:0]       rd_addr_MW,
    input  logic             reg_wrMW,
    input  logic             dmem_req_MW,
    input  logic             dmem_ready,
    input  logic             irq_pending,
    input  logic             is_mretMW,
    input  logic             br_taken_EX,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic             stall,
    output logic             flush_IF,
    output logic             flush_EX,
    output logic [1:0]       pc_sel,
    output logic             trap_take,
    output logic             mem_fault,
    output logic             dmem_abort
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] trap_cnt
`endif
);

    localparam int unsigned     CntW       = wait_cnt_width(MEM_TIMEOUT);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(MEM_TIMEOUT);
    // With the timeout disabled the counter simply rests at zero
    localparam logic [CntW-1:0] CntStart   = (MEM_TIMEOUT == 0) ? '0 : CntW'(1);
    localparam bit              TimeoutEn  = (MEM_TIMEOUT != 0);

    hz_state_e       state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            take_rules;
    logic            csr_mask;

    fwd_unit u_fwd_unit (
        .rs1_addr_i (rs1_addr_EX),
        .rs2_addr_i (rs2_addr_EX),
        .rd_addr_i  (rd_addr_MW),
        .reg_wr_i   (reg_wrMW),
        .fwd_a_o    (fwd_a),
        .fwd_b_o    (fwd_b)
    );

    // Next state, wait counter and pipeline control, all held quiet during reset
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stall      = 1'b0;
        flush_IF   = 1'b0;
        flush_EX   = 1'b0;
        pc_sel     = PC_PLUS4;
        trap_take  = 1'b0;
        mem_fault  = 1'b0;
        dmem_abort = 1'b0;
        take_rules = 1'b0;
        csr_mask   = 1'b0;

        if (!rst) begin
            case (state_q)
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        // Access done: resume and arbitrate redirects this same cycle
                        wait_cnt_d = '0;
                        state_d    = RUN;
                        take_rules = 1'b1;
                    end else if (TimeoutEn && (wait_cnt_q == TimeoutVal)) begin
                        dmem_abort = 1'b1;
                        mem_fault  = 1'b1;
                        trap_take  = 1'b1;
                        pc_sel     = PC_MTVEC;
                        flush_IF   = 1'b1;
                        flush_EX   = 1'b1;
                        wait_cnt_d = '0;
                        state_d    = REDIRECT;
                    end else begin
                        stall = 1'b1;
                        if (wait_cnt_q != TimeoutVal) begin
                            wait_cnt_d = wait_cnt_q + CntW'(1);
                        end
                    end
                end
                REDIRECT: begin
                    // mstatus is still settling from the previous redirect
                    csr_mask   = 1'b1;
                    state_d    = RUN;
                    take_rules = 1'b1;
                end
                default: begin
                    take_rules = 1'b1;
                end
            endcase

            if (take_rules) begin
                if (dmem_req_MW && !dmem_ready) begin
                    stall      = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CntStart;
                end else if (irq_pending && !csr_mask) begin
                    trap_take = 1'b1;
                    pc_sel    = PC_MTVEC;
                    flush_IF  = 1'b1;
                    flush_EX  = 1'b1;
                    state_d   = REDIRECT;
                end else if (is_mretMW && !csr_mask) begin
                    pc_sel   = PC_MEPC;
                    flush_IF = 1'b1;
                    flush_EX = 1'b1;
                    state_d  = REDIRECT;
                end else if (br_taken_EX) begin
                    pc_sel   = PC_BRANCH;
                    flush_IF = 1'b1;
                end
            end
        end
    end

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, trap_cnt_q;

    // Free-running event counters; they wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            trap_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(stall);
            flush_cnt_q <= flush_cnt_q + CNT_W'(flush_IF);
            trap_cnt_q  <= trap_cnt_q + CNT_W'(trap_take);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign trap_cnt  = trap_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a behavioural model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_hazard_ctrl;

    localparam int unsigned T = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_addr_EX, rs2_addr_EX, rd_addr_MW;
    logic       reg_wrMW, dmem_req_MW, dmem_ready, irq_pending, is_mretMW, br_taken_EX;
    logic       fwd_a, fwd_b, stall, flush_IF, flush_EX, trap_take, mem_fault, dmem_abort;
    logic [1:0] pc_sel;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, trap_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MEM_TIMEOUT (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_addr_EX (rs1_addr_EX),
        .rs2_addr_EX (rs2_addr_EX),
        .rd_addr_MW  (rd_addr_MW),
        .reg_wrMW    (reg_wrMW),
        .dmem_req_MW (dmem_req_MW),
        .dmem_ready  (dmem_ready),
        .irq_pending (irq_pending),
        .is_mretMW   (is_mretMW),
        .br_taken_EX (br_taken_EX),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall       (stall),
        .flush_IF    (flush_IF),
        .flush_EX    (flush_EX),
        .pc_sel      (pc_sel),
        .trap_take   (trap_take),
        .mem_fault   (mem_fault),
        .dmem_abort  (dmem_abort)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .trap_cnt    (trap_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: m_wait = cycles spent waiting on memory (0 = not waiting),
    // m_mask = previous cycle redirected the PC, so irq/mret are ignored now.
    int          m_wait = 0;
    bit          m_mask = 1'b0;
    int unsigned m_sc = 0, m_fc = 0, m_tc = 0;

    always @(negedge clk) begin : model
        bit          e_fa, e_fb, e_st, e_fi, e_fe, e_tr, e_mf, e_ab, redir;
        int          e_pc, n_wait;
        logic [10:0] e_vec, a_vec;
        e_st = 0; e_fi = 0; e_fe = 0; e_tr = 0; e_mf = 0; e_ab = 0; redir = 0;
        e_pc = 0; n_wait = 0;
        e_fa = reg_wrMW && rd_addr_MW != 0 && rd_addr_MW == rs1_addr_EX;
        e_fb = reg_wrMW && rd_addr_MW != 0 && rd_addr_MW == rs2_addr_EX;
        if (!rst) begin
            if (m_wait > 0 && !dmem_ready && T > 0 && m_wait == int'(T)) begin
                e_ab = 1; e_mf = 1; e_tr = 1; e_pc = 2; e_fi = 1; e_fe = 1; redir = 1;
            end else if (m_wait > 0 && !dmem_ready) begin
                e_st = 1; n_wait = m_wait + 1;
            end else if (m_wait == 0 && dmem_req_MW && !dmem_ready) begin
                e_st = 1; n_wait = 1;
            end else if (irq_pending && !m_mask) begin
                e_tr = 1; e_pc = 2; e_fi = 1; e_fe = 1; redir = 1;
            end else if (is_mretMW && !m_mask) begin
                e_pc = 3; e_fi = 1; e_fe = 1; redir = 1;
            end else if (br_taken_EX) begin
                e_pc = 1; e_fi = 1;
            end
        end
        e_vec = {e_fa, e_fb, e_st, e_fi, e_fe, e_pc[1:0], e_tr, e_mf, e_ab};
        a_vec = {fwd_a, fwd_b, stall, flush_IF, flush_EX, pc_sel, trap_take, mem_fault,
                 dmem_abort};
        chk("cycle_outputs", 32'(a_vec), 32'(e_vec));
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_sc);
        chk("flush_cnt", flush_cnt, m_fc);
        chk("trap_cnt", trap_cnt, m_tc);
`endif
        if (rst) begin
            m_sc = 0; m_fc = 0; m_tc = 0;
        end else begin
            m_sc += e_st; m_fc += e_fi; m_tc += e_tr;
        end
        m_wait = n_wait;
        m_mask = redir;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input bit req, input bit rdy, input bit irq, input bit mret,
                          input bit br);
        dmem_req_MW = req; dmem_ready = rdy; irq_pending = irq; is_mretMW = mret;
        br_taken_EX = br;
    endtask

    initial begin
        rst = 1'b1;
        rs1_addr_EX = '0; rs2_addr_EX = '0; rd_addr_MW = '0; reg_wrMW = 1'b0;
        set_in(0, 0, 0, 0, 0);
        tick(); tick();

        // Reset holds every control output low even with requests present
        set_in(1, 0, 1, 1, 1);
        look();
        chk("reset_stall", 32'(stall), 0);
        chk("reset_pc_sel", 32'(pc_sel), 0);
        chk("reset_trap", 32'(trap_take), 0);

        // Forwarding
        tick(); rst = 1'b0; set_in(0, 0, 0, 0, 0);
        rd_addr_MW = 5'd5; reg_wrMW = 1'b1; rs1_addr_EX = 5'd5; rs2_addr_EX = 5'd5;
        look();
        chk("fwd_a_match", 32'(fwd_a), 1);
        chk("fwd_b_match", 32'(fwd_b), 1);
        tick(); rd_addr_MW = 5'd0; rs1_addr_EX = 5'd0; rs2_addr_EX = 5'd0;
        look();
        chk("fwd_a_x0", 32'(fwd_a), 0);
        chk("fwd_b_x0", 32'(fwd_b), 0);
        tick(); reg_wrMW = 1'b0;

        // Memory wait of three cycles, ready on the fourth
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0, 0);
            look();
            chk("wait_stall", 32'(stall), 1);
            tick();
        end
        set_in(1, 1, 0, 0, 0);
        look();
        chk("wait_done_stall", 32'(stall), 0);
        chk("wait_done_fault", 32'(mem_fault), 0);
        tick();

        // Timeout: four stall cycles, then the fault cycle
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 0, 0);
            look();
            chk("to_stall", 32'(stall), 1);
            chk("to_no_abort", 32'(dmem_abort), 0);
            tick();
        end
        look();
        chk("to_abort", 32'(dmem_abort), 1);
        chk("to_fault", 32'(mem_fault), 1);
        chk("to_trap", 32'(trap_take), 1);
        chk("to_pc_sel", 32'(pc_sel), 2);
        chk("to_flushes", 32'({flush_IF, flush_EX, stall}), 32'b110);
        tick(); set_in(0, 1, 1, 0, 0);
        look();
        chk("to_redirect_mask", 32'(trap_take), 0);
        tick();
        look();
        chk("to_back_in_run", 32'(trap_take), 1);
        tick(); set_in(0, 1, 0, 0, 1);
        look();
        chk("redirect_branch_pc", 32'(pc_sel), 1);
        tick(); set_in(0, 0, 0, 0, 0);
        tick();

        // Interrupt beats branch; held irq is masked for one cycle
        set_in(0, 0, 1, 0, 1);
        look();
        chk("irq_pc_sel", 32'(pc_sel), 2);
        chk("irq_trap", 32'(trap_take), 1);
        chk("irq_flush_EX", 32'(flush_EX), 1);
        tick(); set_in(0, 0, 1, 0, 0);
        look();
        chk("irq_masked_trap", 32'(trap_take), 0);
        chk("irq_masked_pc", 32'(pc_sel), 0);
        tick(); set_in(0, 0, 0, 0, 0);
        tick();

        // mret during memory wait: stall only, honoured on the ready cycle
        set_in(1, 0, 0, 1, 0);
        look();
        chk("mret_wait_stall", 32'(stall), 1);
        chk("mret_wait_pc", 32'(pc_sel), 0);
        tick();
        look();
        chk("mret_wait2_pc", 32'(pc_sel), 0);
        tick(); set_in(1, 1, 0, 1, 0);
        look();
        chk("mret_ready_pc", 32'(pc_sel), 3);
        chk("mret_ready_flush", 32'({stall, flush_IF, flush_EX}), 32'b011);
        tick(); set_in(0, 0, 0, 1, 0);
        look();
        chk("mret_redirect_pc", 32'(pc_sel), 0);
        tick(); set_in(0, 0, 0, 0, 0);
        tick();

        // Reset in the middle of a memory wait
        set_in(1, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b1;
        look();
        chk("rst_wait_stall", 32'(stall), 0);
        tick(); rst = 1'b0; set_in(0, 0, 0, 0, 0);
        look();
        chk("rst_after_stall", 32'(stall), 0);
        chk("rst_after_pulses", 32'({trap_take, mem_fault, dmem_abort}), 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_after_cnt", stall_cnt | flush_cnt | trap_cnt, 0);
`endif
        tick();

        // Randomized traffic with occasional memory hangs and resets
        begin
            int hang = 0;
            for (int i = 0; i < 3000; i++) begin
                if (hang == 0 && $urandom_range(0, 19) == 0) hang = $urandom_range(1, 8);
                dmem_req_MW = $urandom_range(0, 1) == 1;
                dmem_ready  = (hang > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (hang > 0) hang--;
                irq_pending = $urandom_range(0, 7) == 0;
                is_mretMW   = $urandom_range(0, 7) == 0;
                br_taken_EX = $urandom_range(0, 3) == 0;
                reg_wrMW    = $urandom_range(0, 1) == 1;
                rd_addr_MW  = 5'($urandom_range(0, 3));
                rs1_addr_EX = 5'($urandom_range(0, 3));
                rs2_addr_EX = 5'($urandom_range(0, 3));
                rst         = $urandom_range(0, 149) == 0;
                tick();
            end
        end
        rst = 1'b0;
        look();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
